// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types for the hazard scheduler and the pipeline-register
// enable/reset controller that consumes its hazard code.
//   hazard_op_e   : 2-bit code driven to the pipeline-register controller
//   sb_entry_t    : one shadow-scoreboard slot {valid, rd}
//   sched_state_e : scheduler FSM state
//   src_match     : true when a used, non-x0 source hits a valid slot
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN  = 2'd0,
    HZ_DATA = 2'd1,
    HZ_CTRL = 2'd2
  } hazard_op_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } sched_state_e;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, rd: 5'd0};

  function automatic logic src_match(input logic       used,
                                     input logic [4:0] rs,
                                     input sb_entry_t  entry);
    return used && (rs != 5'd0) && entry.valid && (entry.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// ---------------------------------------------------------------------------
// hazard_scheduler_if
// Bundles the ID/EX observation signals and the scheduler outputs.
// Suffixes are relative to the scheduler: _i flows into it, _o out of it.
//   id_rs1_i/id_rs2_i, id_rs1_used_i/id_rs2_used_i : ID source operands
//   id_rd_i, id_rd_wr_i                            : ID destination
//   ex_branch_taken_i                              : taken branch in EX
//   hazard_op_o                                    : run / stall / flush code
//   stall_count_o, flush_count_o                   : saturating event counts
// Modports: master = pipeline side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface hazard_scheduler_if #(
  parameter int CNT_W = 32
);
  import hazard_pkg::*;

  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_rs1_used_i;
  logic             id_rs2_used_i;
  logic [4:0]       id_rd_i;
  logic             id_rd_wr_i;
  logic             ex_branch_taken_i;
  hazard_op_e       hazard_op_o;
  logic [CNT_W-1:0] stall_count_o;
  logic [CNT_W-1:0] flush_count_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_rd_wr_i, ex_branch_taken_i,
    input  hazard_op_o, stall_count_o, flush_count_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_rd_wr_i, ex_branch_taken_i,
    output hazard_op_o, stall_count_o, flush_count_o
  );

endinterface

// File: rtl/hazard_scheduler_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   clk_i   : clock
//   inc_i   : count one event this cycle
//   clear_i : synchronous clear (wins over inc_i)
//   count_o : current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !(&count_q)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_scheduler.sv
// ---------------------------------------------------------------------------
// hazard_scheduler
// RAW-hazard detection and branch-flush sequencing for a non-forwarding
// five-stage pipeline. A three-slot shadow scoreboard (EX/MEM/WB) tracks
// in-flight destinations; the ID sources are compared against it each cycle.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   hz     : hazard_scheduler_if.slave (ID/EX inputs, hazard code, counters)
// Parameters: FLUSH_CYCLES (1..7), WB_BYPASS (write-before-read regfile),
// CNT_W (counter width, must match the interface).
// ---------------------------------------------------------------------------
module hazard_scheduler
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int WB_BYPASS    = 1,
  parameter int CNT_W        = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  hazard_scheduler_if.slave   hz
);

  localparam logic CHECK_WB = (WB_BYPASS == 0);

  sb_entry_t    sb_ex_q, sb_mem_q, sb_wb_q;
  sb_entry_t    sb_ex_d;
  sched_state_e state_q, state_d;
  logic [2:0]   flush_left_q, flush_left_d;
  hazard_op_e   hazard_op;

  logic [4:0]   src_rs   [2];
  logic         src_used [2];
  logic [1:0]   src_hit;
  logic         data_hazard;

  assign src_rs[0]   = hz.id_rs1_i;
  assign src_rs[1]   = hz.id_rs2_i;
  assign src_used[0] = hz.id_rs1_used_i;
  assign src_used[1] = hz.id_rs2_used_i;

  // One compare bank per source; the WB slot only matters when the
  // register file cannot forward a same-cycle write to the read port.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_match(src_used[gi], src_rs[gi], sb_ex_q)
                         | src_match(src_used[gi], src_rs[gi], sb_mem_q)
                         | (CHECK_WB & src_match(src_used[gi], src_rs[gi], sb_wb_q));
    end
  endgenerate

  assign data_hazard = |src_hit;

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    hazard_op    = HZ_RUN;

    unique case (state_q)
      ST_RUN: begin
        // Control wins: the ID instruction is wrong-path on a taken branch.
        if (hz.ex_branch_taken_i) begin
          hazard_op = HZ_CTRL;
          if (FLUSH_CYCLES > 1) begin
            state_d      = ST_FLUSH;
            flush_left_d = 3'(FLUSH_CYCLES - 1);
          end
        end else if (data_hazard) begin
          hazard_op = HZ_DATA;
        end
      end
      ST_FLUSH: begin
        // Further branch indications are wrong-path and ignored here.
        hazard_op    = HZ_CTRL;
        flush_left_d = flush_left_q - 3'd1;
        if (flush_left_q == 3'd1) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (!rst_ni) begin
      hazard_op = HZ_RUN;
    end
  end

  // Only an instruction that actually advances out of ID occupies the EX
  // slot; stalls and flushes insert a bubble.
  always_comb begin
    sb_ex_d = SB_EMPTY;
    if ((hazard_op == HZ_RUN) && hz.id_rd_wr_i && (hz.id_rd_i != 5'd0)) begin
      sb_ex_d = '{valid: 1'b1, rd: hz.id_rd_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sb_ex_q      <= SB_EMPTY;
      sb_mem_q     <= SB_EMPTY;
      sb_wb_q      <= SB_EMPTY;
      state_q      <= ST_RUN;
      flush_left_q <= 3'd0;
    end else begin
      sb_ex_q      <= sb_ex_d;
      sb_mem_q     <= sb_ex_q;
      sb_wb_q      <= sb_mem_q;
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
    end
  end

  assign hz.hazard_op_o = hazard_op;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .inc_i   (hazard_op == HZ_DATA),
    .clear_i (!rst_ni),
    .count_o (hz.stall_count_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .inc_i   (hazard_op == HZ_CTRL),
    .clear_i (!rst_ni),
    .count_o (hz.flush_count_o)
  );

endmodule

// File: tb/tb_hazard_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hazard_scheduler
// Two schedulers see identical stimulus:
//   dut_a : FLUSH_CYCLES=3, WB_BYPASS=1, CNT_W=4
//   dut_b : FLUSH_CYCLES=1, WB_BYPASS=0, CNT_W=32
// Each scenario builds a per-cycle stimulus list with the hand-derived
// hazard code for both instances; expected codes are queued when a cycle
// is driven and popped when the outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_scheduler;
  import hazard_pkg::*;

  typedef struct packed {
    logic       rst_n;
    logic       br;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       br;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, wr;

  int checks   = 0;
  int failures = 0;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];

  always #5 clk = ~clk;

  hazard_scheduler_if #(.CNT_W(4))  if_a ();
  hazard_scheduler_if #(.CNT_W(32)) if_b ();

  assign if_a.id_rs1_i          = rs1;
  assign if_a.id_rs2_i          = rs2;
  assign if_a.id_rs1_used_i     = u1;
  assign if_a.id_rs2_used_i     = u2;
  assign if_a.id_rd_i           = rd;
  assign if_a.id_rd_wr_i        = wr;
  assign if_a.ex_branch_taken_i = br;
  assign if_b.id_rs1_i          = rs1;
  assign if_b.id_rs2_i          = rs2;
  assign if_b.id_rs1_used_i     = u1;
  assign if_b.id_rs2_used_i     = u2;
  assign if_b.id_rd_i           = rd;
  assign if_b.id_rd_wr_i        = wr;
  assign if_b.ex_branch_taken_i = br;

  hazard_scheduler #(.FLUSH_CYCLES(3), .WB_BYPASS(1), .CNT_W(4)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .hz     (if_a.slave)
  );

  hazard_scheduler #(.FLUSH_CYCLES(1), .WB_BYPASS(0), .CNT_W(32)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .hz     (if_b.slave)
  );

  function automatic stim_t mk(input logic r, input logic b,
                               input logic [4:0] s1, input logic us1,
                               input logic [4:0] s2, input logic us2,
                               input logic [4:0] d, input logic w);
    stim_t s;
    s.rst_n = r; s.br = b; s.rs1 = s1; s.u1 = us1;
    s.rs2 = s2; s.u2 = us2; s.rd = d; s.wr = w;
    return s;
  endfunction

  // Common instructions
  localparam stim_t S_RST = '{rst_n: 1'b0, br: 1'b0, rs1: 5'd0, u1: 1'b0,
                              rs2: 5'd0, u2: 1'b0, rd: 5'd0, wr: 1'b0};
  localparam stim_t S_NOP = '{rst_n: 1'b1, br: 1'b0, rs1: 5'd0, u1: 1'b0,
                              rs2: 5'd0, u2: 1'b0, rd: 5'd0, wr: 1'b0};
  localparam stim_t S_BR  = '{rst_n: 1'b1, br: 1'b1, rs1: 5'd0, u1: 1'b0,
                              rs2: 5'd0, u2: 1'b0, rd: 5'd0, wr: 1'b0};

  task automatic apply(input stim_t s);
    rst_n = s.rst_n; br = s.br;
    rs1 = s.rs1; u1 = s.u1; rs2 = s.rs2; u2 = s.u2;
    rd = s.rd; wr = s.wr;
  endtask

  task automatic test_reset();
    stim_t st[$];
    logic [1:0] ea[$], eb[$];
    logic [1:0] xa, xb;
    // branch and a would-be hazard while in reset: code stays 0
    st.push_back(mk(1'b0, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1)); ea.push_back(0); eb.push_back(0);
    st.push_back(S_RST); ea.push_back(0); eb.push_back(0);
    for (int c = 0; c < st.size(); c++) begin
      apply(st[c]); q_a.push_back(ea[c]); q_b.push_back(eb[c]);
      @(negedge clk);
      xa = q_a.pop_front(); xb = q_b.pop_front();
      checks++;
      if (if_a.hazard_op_o !== xa) begin failures++; $display("FAIL reset_op_a cyc %0d: got %0d want %0d", c, if_a.hazard_op_o, xa); end
      checks++;
      if (if_b.hazard_op_o !== xb) begin failures++; $display("FAIL reset_op_b cyc %0d: got %0d want %0d", c, if_b.hazard_op_o, xb); end
      $display("[reset] cyc %0d op_a=%0d op_b=%0d", c, if_a.hazard_op_o, if_b.hazard_op_o);
      @(posedge clk); #1;
    end
    checks++;
    if (if_a.stall_count_o !== 4'd0 || if_a.flush_count_o !== 4'd0) begin
      failures++; $display("FAIL reset_cnt_a: stall=%0d flush=%0d want 0 0", if_a.stall_count_o, if_a.flush_count_o);
    end
    checks++;
    if (if_b.stall_count_o !== 32'd0 || if_b.flush_count_o !== 32'd0) begin
      failures++; $display("FAIL reset_cnt_b: stall=%0d flush=%0d want 0 0", if_b.stall_count_o, if_b.flush_count_o);
    end
  endtask

  task automatic test_raw();
    stim_t st[$];
    logic [1:0] ea[$], eb[$];
    logic [1:0] xa, xb;
    stim_t p, cns;
    p   = mk(1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1); // addi x5,x1,imm
    cns = mk(1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1); // add x6,x5,x1
    st.push_back(S_RST); ea.push_back(0); eb.push_back(0);
    st.push_back(p);     ea.push_back(0); eb.push_back(0);
    st.push_back(cns);   ea.push_back(1); eb.push_back(1);
    st.push_back(cns);   ea.push_back(1); eb.push_back(1);
    st.push_back(cns);   ea.push_back(0); eb.push_back(1);
    st.push_back(cns);   ea.push_back(0); eb.push_back(0);
    st.push_back(S_NOP); ea.push_back(0); eb.push_back(0);
    for (int c = 0; c < st.size(); c++) begin
      apply(st[c]); q_a.push_back(ea[c]); q_b.push_back(eb[c]);
      @(negedge clk);
      xa = q_a.pop_front(); xb = q_b.pop_front();
      checks++;
      if (if_a.hazard_op_o !== xa) begin failures++; $display("FAIL raw_op_a cyc %0d: got %0d want %0d", c, if_a.hazard_op_o, xa); end
      checks++;
      if (if_b.hazard_op_o !== xb) begin failures++; $display("FAIL raw_op_b cyc %0d: got %0d want %0d", c, if_b.hazard_op_o, xb); end
      $display("[raw] cyc %0d op_a=%0d op_b=%0d", c, if_a.hazard_op_o, if_b.hazard_op_o);
      @(posedge clk); #1;
    end
    checks++;
    if (if_a.stall_count_o !== 4'd2) begin failures++; $display("FAIL raw_stall_cnt_a: got %0d want 2", if_a.stall_count_o); end
    checks++;
    if (if_b.stall_count_o !== 32'd3) begin failures++; $display("FAIL raw_stall_cnt_b: got %0d want 3", if_b.stall_count_o); end
  endtask

  task automatic test_x0_unused();
    stim_t st[$];
    logic [1:0] ea[$], eb[$];
    logic [1:0] xa, xb;
    stim_t u, v;
    u = mk(1'b1, 1'b0, 5'd3, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0); // rs2=x7 not read
    v = mk(1'b1, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0); // rs2=x7 read
    st.push_back(S_RST); ea.push_back(0); eb.push_back(0);
    st.push_back(mk(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1)); ea.push_back(0); eb.push_back(0);
    st.push_back(mk(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1)); ea.push_back(0); eb.push_back(0);
    st.push_back(mk(1'b1, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1)); ea.push_back(0); eb.push_back(0);
    st.push_back(u);     ea.push_back(0); eb.push_back(0);
    st.push_back(v);     ea.push_back(1); eb.push_back(1);
    st.push_back(v);     ea.push_back(0); eb.push_back(1);
    st.push_back(v);     ea.push_back(0); eb.push_back(0);
    st.push_back(S_NOP); ea.push_back(0); eb.push_back(0);
    for (int c = 0; c < st.size(); c++) begin
      apply(st[c]); q_a.push_back(ea[c]); q_b.push_back(eb[c]);
      @(negedge clk);
      xa = q_a.pop_front(); xb = q_b.pop_front();
      checks++;
      if (if_a.hazard_op_o !== xa) begin failures++; $display("FAIL x0_op_a cyc %0d: got %0d want %0d", c, if_a.hazard_op_o, xa); end
      checks++;
      if (if_b.hazard_op_o !== xb) begin failures++; $display("FAIL x0_op_b cyc %0d: got %0d want %0d", c, if_b.hazard_op_o, xb); end
      $display("[x0_unused] cyc %0d op_a=%0d op_b=%0d", c, if_a.hazard_op_o, if_b.hazard_op_o);
      @(posedge clk); #1;
    end
    checks++;
    if (if_a.stall_count_o !== 4'd1) begin failures++; $display("FAIL x0_stall_cnt_a: got %0d want 1", if_a.stall_count_o); end
    checks++;
    if (if_b.stall_count_o !== 32'd2) begin failures++; $display("FAIL x0_stall_cnt_b: got %0d want 2", if_b.stall_count_o); end
  endtask

  task automatic test_branch();
    stim_t st[$];
    logic [1:0] ea[$], eb[$];
    logic [1:0] xa, xb;
    st.push_back(S_RST); ea.push_back(0); eb.push_back(0);
    st.push_back(S_BR);  ea.push_back(2); eb.push_back(2);
    st.push_back(S_NOP); ea.push_back(2); eb.push_back(0);
    st.push_back(S_BR);  ea.push_back(2); eb.push_back(2); // ignored by dut_a mid-flush
    st.push_back(S_NOP); ea.push_back(0); eb.push_back(0);
    st.push_back(S_NOP); ea.push_back(0); eb.push_back(0);
    for (int c = 0; c < st.size(); c++) begin
      apply(st[c]); q_a.push_back(ea[c]); q_b.push_back(eb[c]);
      @(negedge clk);
      xa = q_a.pop_front(); xb = q_b.pop_front();
      checks++;
      if (if_a.hazard_op_o !== xa) begin failures++; $display("FAIL branch_op_a cyc %0d: got %0d want %0d", c, if_a.hazard_op_o, xa); end
      checks++;
      if (if_b.hazard_op_o !== xb) begin failures++; $display("FAIL branch_op_b cyc %0d: got %0d want %0d", c, if_b.hazard_op_o, xb); end
      $display("[branch] cyc %0d op_a=%0d op_b=%0d", c, if_a.hazard_op_o, if_b.hazard_op_o);
      @(posedge clk); #1;
    end
    checks++;
    if (if_a.flush_count_o !== 4'd3) begin failures++; $display("FAIL branch_flush_cnt_a: got %0d want 3", if_a.flush_count_o); end
    checks++;
    if (if_b.flush_count_o !== 32'd2) begin failures++; $display("FAIL branch_flush_cnt_b: got %0d want 2", if_b.flush_count_o); end
  endtask

  task automatic test_simultaneous();
    stim_t st[$];
    logic [1:0] ea[$], eb[$];
    logic [1:0] xa, xb;
    st.push_back(S_RST); ea.push_back(0); eb.push_back(0);
    st.push_back(mk(1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1)); ea.push_back(0); eb.push_back(0);
    // reads x5 (hazard) and writes x9, with a taken branch in EX
    st.push_back(mk(1'b1, 1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1)); ea.push_back(2); eb.push_back(2);
    // reads x9: dut_b stalls only if the flushed instruction was recorded
    st.push_back(mk(1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0)); ea.push_back(2); eb.push_back(0);
    st.push_back(S_NOP); ea.push_back(2); eb.push_back(0);
    st.push_back(S_NOP); ea.push_back(0); eb.push_back(0);
    for (int c = 0; c < st.size(); c++) begin
      apply(st[c]); q_a.push_back(ea[c]); q_b.push_back(eb[c]);
      @(negedge clk);
      xa = q_a.pop_front(); xb = q_b.pop_front();
      checks++;
      if (if_a.hazard_op_o !== xa) begin failures++; $display("FAIL simul_op_a cyc %0d: got %0d want %0d", c, if_a.hazard_op_o, xa); end
      checks++;
      if (if_b.hazard_op_o !== xb) begin failures++; $display("FAIL simul_op_b cyc %0d: got %0d want %0d", c, if_b.hazard_op_o, xb); end
      $display("[simultaneous] cyc %0d op_a=%0d op_b=%0d", c, if_a.hazard_op_o, if_b.hazard_op_o);
      @(posedge clk); #1;
    end
    checks++;
    if (if_b.stall_count_o !== 32'd0 || if_b.flush_count_o !== 32'd1) begin
      failures++; $display("FAIL simul_cnt_b: stall=%0d flush=%0d want 0 1", if_b.stall_count_o, if_b.flush_count_o);
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[$];
    logic [1:0] ea[$], eb[$];
    logic [1:0] xa, xb;
    stim_t p, cns, cns_r, nop_r;
    p     = mk(1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    cns   = mk(1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1);
    cns_r = cns; cns_r.rst_n = 1'b0;
    nop_r = S_NOP; nop_r.rst_n = 1'b0;
    st.push_back(S_RST); ea.push_back(0); eb.push_back(0);
    st.push_back(p);     ea.push_back(0); eb.push_back(0);
    st.push_back(cns);   ea.push_back(1); eb.push_back(1);
    st.push_back(cns_r); ea.push_back(0); eb.push_back(0);
    st.push_back(cns);   ea.push_back(0); eb.push_back(0);
    st.push_back(S_BR);  ea.push_back(2); eb.push_back(2);
    st.push_back(nop_r); ea.push_back(0); eb.push_back(0);
    st.push_back(S_NOP); ea.push_back(0); eb.push_back(0);
    st.push_back(S_NOP); ea.push_back(0); eb.push_back(0);
    for (int c = 0; c < st.size(); c++) begin
      apply(st[c]); q_a.push_back(ea[c]); q_b.push_back(eb[c]);
      @(negedge clk);
      xa = q_a.pop_front(); xb = q_b.pop_front();
      checks++;
      if (if_a.hazard_op_o !== xa) begin failures++; $display("FAIL rstmid_op_a cyc %0d: got %0d want %0d", c, if_a.hazard_op_o, xa); end
      checks++;
      if (if_b.hazard_op_o !== xb) begin failures++; $display("FAIL rstmid_op_b cyc %0d: got %0d want %0d", c, if_b.hazard_op_o, xb); end
      $display("[reset_mid] cyc %0d op_a=%0d op_b=%0d", c, if_a.hazard_op_o, if_b.hazard_op_o);
      @(posedge clk); #1;
    end
    checks++;
    if (if_a.stall_count_o !== 4'd0 || if_a.flush_count_o !== 4'd0) begin
      failures++; $display("FAIL rstmid_cnt_a: stall=%0d flush=%0d want 0 0", if_a.stall_count_o, if_a.flush_count_o);
    end
    checks++;
    if (if_b.stall_count_o !== 32'd0 || if_b.flush_count_o !== 32'd0) begin
      failures++; $display("FAIL rstmid_cnt_b: stall=%0d flush=%0d want 0 0", if_b.stall_count_o, if_b.flush_count_o);
    end
  endtask

  task automatic test_saturation();
    stim_t st[$];
    logic [1:0] ea[$], eb[$];
    logic [1:0] xa, xb;
    stim_t self_dep;
    self_dep = mk(1'b1, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1); // add x5,x5,x1
    st.push_back(S_RST); ea.push_back(0); eb.push_back(0);
    // each issue of x5<-x5 costs 2 stalls (bypass) or 3 (no bypass)
    for (int k = 0; k < 30; k++) begin
      st.push_back(self_dep);
      ea.push_back((k % 3 == 0) ? 2'd0 : 2'd1);
      eb.push_back((k % 4 == 0) ? 2'd0 : 2'd1);
    end
    st.push_back(S_NOP); ea.push_back(0); eb.push_back(0);
    for (int c = 0; c < st.size(); c++) begin
      apply(st[c]); q_a.push_back(ea[c]); q_b.push_back(eb[c]);
      @(negedge clk);
      xa = q_a.pop_front(); xb = q_b.pop_front();
      checks++;
      if (if_a.hazard_op_o !== xa) begin failures++; $display("FAIL sat_op_a cyc %0d: got %0d want %0d", c, if_a.hazard_op_o, xa); end
      checks++;
      if (if_b.hazard_op_o !== xb) begin failures++; $display("FAIL sat_op_b cyc %0d: got %0d want %0d", c, if_b.hazard_op_o, xb); end
      $display("[saturation] cyc %0d op_a=%0d op_b=%0d cnt_a=%0d", c, if_a.hazard_op_o, if_b.hazard_op_o, if_a.stall_count_o);
      @(posedge clk); #1;
    end
    checks++;
    if (if_a.stall_count_o !== 4'd15) begin failures++; $display("FAIL sat_stall_cnt_a: got %0d want 15", if_a.stall_count_o); end
    checks++;
    if (if_b.stall_count_o !== 32'd22) begin failures++; $display("FAIL sat_stall_cnt_b: got %0d want 22", if_b.stall_count_o); end
  endtask

  initial begin
    apply(S_RST);
    @(posedge clk); #1;
    test_reset();
    test_raw();
    test_x0_unused();
    test_branch();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
